// File: rtl/sram_req_arb_pkg.sv
// sram_arb_pkg: shared types, defaults and index-width helper for the SRAM request arbiter
package sram_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;
  localparam int NCH_DEF = 2;
  localparam int TO_W_DEF = 8;
  localparam int TIMEOUT_DEF = 200;
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sram_req_arb_if.sv
// sram_req_arb_if: request/grant bundle between memory requesters, SRAM ack and the arbiter
interface sram_req_arb_if import sram_arb_pkg::*; #(parameter int NCH = NCH_DEF);
  localparam int IW = idx_w(NCH);
  logic [NCH-1:0] req_rden;
  logic [NCH-1:0] req_wren;
  logic [NCH-1:0] req_cs;
  logic           ack;
  logic           err_clr;
  logic [NCH-1:0] grant_oh;
  logic [IW-1:0]  grant_idx;
  logic           busy;
  logic [NCH-1:0] stall;
  logic           abort;
  logic           timeout_err;
  modport master (
    output req_rden, req_wren, req_cs, ack, err_clr,
    input  grant_oh, grant_idx, busy, stall, abort, timeout_err
  );
  modport slave (
    input  req_rden, req_wren, req_cs, ack, err_clr,
    output grant_oh, grant_idx, busy, stall, abort, timeout_err
  );
endinterface

// File: rtl/sram_req_arb_rr.sv
// rr_arbiter: combinational round-robin pick of the first request after last, skipping excluded channels
module rr_arbiter import sram_arb_pkg::*; #(
  parameter int NCH = NCH_DEF,
  localparam int IW = idx_w(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [IW-1:0]  last_i,
  input  logic [NCH-1:0] excl_i,
  output logic [NCH-1:0] gnt_oh_o,
  output logic [IW-1:0]  gnt_idx_o,
  output logic           valid_o
);
  logic [NCH-1:0] m;
  assign m = req_i & ~excl_i;
  // lowest request overall is the wrap-around fallback; lowest above last overrides it
  always_comb begin
    gnt_idx_o = '0;
    valid_o = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) if (m[i]) begin
      gnt_idx_o = IW'(i);
      valid_o = 1'b1;
    end
    for (int i = NCH - 1; i >= 0; i--) if (m[i] && i > int'(last_i)) gnt_idx_o = IW'(i);
    gnt_oh_o = valid_o ? NCH'(1) << gnt_idx_o : '0;
  end
endmodule

// File: rtl/sram_req_arb.sv
// sram_req_arb: round-robin SRAM port controller with held grants, back-to-back handoff and ack timeout
module sram_req_arb import sram_arb_pkg::*; #(
  parameter int NCH = NCH_DEF,
  parameter int TO_W = TO_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic clk,
  input logic rst,
  sram_req_arb_if.slave bus
);
  localparam int IW = idx_w(NCH);
  arb_state_t     state_q, state_d;
  logic [NCH-1:0] grant_oh_q, grant_oh_d, req, win_oh, excl;
  logic [IW-1:0]  grant_idx_q, grant_idx_d, last_q, last_d, win_idx, arb_last;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic           err_q, err_d, win_vld, in_wait, acked, expire, done, load;
  assign req = (bus.req_rden | bus.req_wren) & bus.req_cs;
  assign in_wait = state_q == ARB_WAIT;
  assign acked = in_wait & bus.ack;
  assign expire = in_wait & ~bus.ack & (TIMEOUT != 0) & (cnt_q == TO_W'(TIMEOUT - 1));
  assign done = acked | expire;
  assign load = ~in_wait | done;
  // on completion the finishing channel becomes the new last and is kept out of the same-cycle pick
  assign arb_last = in_wait ? grant_idx_q : last_q;
  assign excl = in_wait ? grant_oh_q : '0;
  rr_arbiter #(.NCH(NCH)) u_arb (
    .req_i(req),
    .last_i(arb_last),
    .excl_i(excl),
    .gnt_oh_o(win_oh),
    .gnt_idx_o(win_idx),
    .valid_o(win_vld)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_oh_q <= '0;
      grant_idx_q <= '0;
      last_q <= IW'(NCH - 1);
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_oh_q <= grant_oh_d;
      grant_idx_q <= grant_idx_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    state_d = load ? (win_vld ? ARB_WAIT : ARB_IDLE) : ARB_WAIT;
    grant_oh_d = load ? win_oh : grant_oh_q;
    grant_idx_d = load ? win_idx : grant_idx_q;
    last_d = done ? grant_idx_q : last_q;
    cnt_d = load ? '0 : cnt_q + TO_W'(cnt_q != '1);
    err_d = expire | (err_q & ~bus.err_clr);
  end
  always_comb begin
    bus.grant_oh = grant_oh_q;
    bus.grant_idx = grant_idx_q;
    bus.busy = in_wait;
    bus.stall = req & ~(grant_oh_q & {NCH{done}});
    bus.abort = expire;
    bus.timeout_err = err_q;
  end
endmodule
